// File: rtl/write_pointer_full_generate_if.sv
// rtl/write_pointer_full_generate_if.sv - write-side FIFO pointer/flag bundle
interface write_pointer_full_generate_if #(
    parameter int address_size = 4
);
    logic                    write_inc;
    logic [address_size:0]   read_gray_pointer;
    logic                    overflow_clear;
    logic [address_size-1:0] write_address;
    logic [address_size:0]   write_gray_pointer;
    logic                    write_ram_enable;
    logic                    write_full;
    logic                    write_almost_full;
    logic [address_size:0]   write_level;
    logic                    write_overflow;

    modport master (
        output write_inc,
        output read_gray_pointer,
        output overflow_clear,
        input  write_address,
        input  write_gray_pointer,
        input  write_ram_enable,
        input  write_full,
        input  write_almost_full,
        input  write_level,
        input  write_overflow
    );

    modport slave (
        input  write_inc,
        input  read_gray_pointer,
        input  overflow_clear,
        output write_address,
        output write_gray_pointer,
        output write_ram_enable,
        output write_full,
        output write_almost_full,
        output write_level,
        output write_overflow
    );
endinterface

// File: rtl/write_pointer_full_generate.sv
// rtl/write_pointer_full_generate.sv - async FIFO write pointer, full/almost-full/level/overflow flags
module write_pointer_full_generate #(
    parameter int address_size       = 4,
    parameter int almost_full_margin = 2
) (
    input  logic write_clk,
    input  logic write_reset,
    write_pointer_full_generate_if.slave bus
);
    localparam int pw    = address_size + 1;
    localparam int depth = 1 << address_size;
    localparam logic [pw-1:0] almost_threshold = pw'(depth - almost_full_margin);

    logic [pw-1:0] wbin;
    logic [pw-1:0] wgray;
    logic [pw-1:0] wbin_next;
    logic [pw-1:0] wgray_next;
    logic [pw-1:0] rq1;
    logic [pw-1:0] rq2;
    logic [pw-1:0] rbin_sync;
    logic [pw-1:0] level_next;
    logic [pw-1:0] full_target;
    logic [pw-1:0] level_q;
    logic          full_q;
    logic          almost_full_q;
    logic          overflow_q;
    logic          accept;

    function automatic logic [pw-1:0] gray_to_bin(input logic [pw-1:0] g);
        logic [pw-1:0] b;
        b[pw-1] = g[pw-1];
        for (int i = pw - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign accept      = bus.write_inc & ~full_q;
    assign wbin_next   = wbin + pw'(accept);
    assign wgray_next  = (wbin_next >> 1) ^ wbin_next;
    assign rbin_sync   = gray_to_bin(rq2);
    assign level_next  = wbin_next - rbin_sync;
    // Full when the write pointer has lapped the read pointer once: top two Gray bits inverted.
    assign full_target = {~rq2[pw-1:pw-2], rq2[pw-3:0]};

    always_ff @(posedge write_clk or negedge write_reset) begin
        if (!write_reset) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= bus.read_gray_pointer;
            rq2 <= rq1;
        end
    end

    always_ff @(posedge write_clk or negedge write_reset) begin
        if (!write_reset) begin
            wbin          <= '0;
            wgray         <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            level_q       <= '0;
        end else begin
            wbin          <= wbin_next;
            wgray         <= wgray_next;
            full_q        <= (wgray_next == full_target);
            almost_full_q <= (level_next >= almost_threshold);
            level_q       <= level_next;
        end
    end

    // Set has priority over clear so a same-cycle overflow is never lost.
    always_ff @(posedge write_clk or negedge write_reset) begin
        if (!write_reset) begin
            overflow_q <= 1'b0;
        end else if (bus.write_inc && full_q) begin
            overflow_q <= 1'b1;
        end else if (bus.overflow_clear) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.write_address      = wbin[address_size-1:0];
    assign bus.write_gray_pointer = wgray;
    assign bus.write_ram_enable   = accept;
    assign bus.write_full         = full_q;
    assign bus.write_almost_full  = almost_full_q;
    assign bus.write_level        = level_q;
    assign bus.write_overflow     = overflow_q;
endmodule

// File: tb/tb_write_pointer_full_generate.sv
// tb/tb_write_pointer_full_generate.sv - directed self-checking bench for write_pointer_full_generate
module tb_write_pointer_full_generate;
    localparam int address_size = 4;

    logic write_clk;
    logic write_reset;
    int   checks;
    int   errors;

    write_pointer_full_generate_if #(.address_size(address_size)) bus ();

    write_pointer_full_generate #(
        .address_size(address_size),
        .almost_full_margin(2)
    ) dut (
        .write_clk(write_clk),
        .write_reset(write_reset),
        .bus(bus)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  32'(bus.write_address), 0);
        check({tag, "_gray"},  32'(bus.write_gray_pointer), 0);
        check({tag, "_full"},  32'(bus.write_full), 0);
        check({tag, "_afull"}, 32'(bus.write_almost_full), 0);
        check({tag, "_level"}, 32'(bus.write_level), 0);
        check({tag, "_ovf"},   32'(bus.write_overflow), 0);
    endtask

    initial begin
        logic [4:0] hist0;
        logic [4:0] hist1;
        logic [4:0] prev_gray;
        checks = 0;
        errors = 0;
        write_reset = 1'b0;
        bus.write_inc = 1'b0;
        bus.read_gray_pointer = '0;
        bus.overflow_clear = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        check("reset_ram_en", 32'(bus.write_ram_enable), 0);
        write_reset = 1'b1;
        tick();
        check("release_addr", 32'(bus.write_address), 0);
        check("release_gray", 32'(bus.write_gray_pointer), 0);

        // Fill 16 entries with the read pointer parked at zero.
        bus.write_inc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("fill_level_%0d", k), 32'(bus.write_level), 32'(k));
            check($sformatf("fill_afull_%0d", k), 32'(bus.write_almost_full), (k >= 14) ? 1 : 0);
            check($sformatf("fill_full_%0d", k),  32'(bus.write_full), (k == 16) ? 1 : 0);
        end
        check("fill_gray", 32'(bus.write_gray_pointer), 32'h18);
        check("fill_ram_en", 32'(bus.write_ram_enable), 0);

        tick();
        check("ovf_set", 32'(bus.write_overflow), 1);
        check("ovf_gray_hold", 32'(bus.write_gray_pointer), 32'h18);
        bus.write_inc = 1'b0;
        bus.overflow_clear = 1'b1;
        tick();
        check("ovf_clear", 32'(bus.write_overflow), 0);
        bus.write_inc = 1'b1;
        tick();
        check("ovf_set_wins", 32'(bus.write_overflow), 1);
        bus.write_inc = 1'b0;
        tick();
        check("ovf_cleared_again", 32'(bus.write_overflow), 0);
        bus.overflow_clear = 1'b0;

        // Read pointer advances by one; full must hold for two edges.
        bus.read_gray_pointer = 5'b00001;
        tick();
        check("drain_full_e1", 32'(bus.write_full), 1);
        tick();
        check("drain_full_e2", 32'(bus.write_full), 1);
        tick();
        check("drain_full_e3", 32'(bus.write_full), 0);
        check("drain_level_e3", 32'(bus.write_level), 15);
        check("drain_afull_e3", 32'(bus.write_almost_full), 1);

        // Simultaneous write and read advance at level 15.
        bus.write_inc = 1'b1;
        bus.read_gray_pointer = 5'b00011;
        tick();
        check("simul_full_a", 32'(bus.write_full), 1);
        check("simul_level_a", 32'(bus.write_level), 16);
        check("simul_gray_a", 32'(bus.write_gray_pointer), 32'h19);
        bus.write_inc = 1'b0;
        tick();
        check("simul_full_b", 32'(bus.write_full), 1);
        tick();
        check("simul_full_c", 32'(bus.write_full), 0);
        check("simul_level_c", 32'(bus.write_level), 15);

        // Clean restart, then wrap with a trailing read pointer.
        write_reset = 1'b0;
        bus.read_gray_pointer = '0;
        tick();
        write_reset = 1'b1;
        tick();
        hist0 = '0;
        hist1 = '0;
        bus.write_inc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [4:0] cnt;
            bus.read_gray_pointer = hist1;
            prev_gray = bus.write_gray_pointer;
            tick();
            cnt = 5'(i + 1);
            check($sformatf("wrap_gray_%0d", i), 32'(bus.write_gray_pointer), 32'(to_gray(cnt)));
            check($sformatf("wrap_onebit_%0d", i), $countones(bus.write_gray_pointer ^ prev_gray), 1);
            check($sformatf("wrap_addr_%0d", i), 32'(bus.write_address), 32'(cnt[3:0]));
            check($sformatf("wrap_full_%0d", i), 32'(bus.write_full), 0);
            hist1 = hist0;
            hist0 = to_gray(cnt);
        end

        // Asynchronous reset with a write pending.
        write_reset = 1'b0;
        #1;
        check_all_zero("midreset");
        bus.write_inc = 1'b0;
        bus.read_gray_pointer = '0;
        tick();
        write_reset = 1'b1;
        tick();
        check("midrel_addr", 32'(bus.write_address), 0);
        check("midrel_gray", 32'(bus.write_gray_pointer), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/write_pointer_full_generate.md
Name: write_pointer_full_generate

Overview:
Write-domain half of the async FIFO pointer logic, the counterpart of read_pointer_empty_generate. It owns the binary and Gray write pointers and drives the RAM write address. It synchronizes the read-domain Gray pointer with two flops and produces the registered full, almost-full and fill-level flags, plus a sticky overflow indicator. Its write_gray_pointer output feeds the read-domain synchronizer.

Parameters:
address_size, 4, RAM address width; FIFO depth = 2**address_size
almost_full_margin, 2, write_almost_full asserts when free slots <= this value (must be < depth)

Ports:
write_clk  input  1  write-domain clock
write_reset  input  1  asynchronous, active-low reset (0 = reset)
write_inc  input  1  write request for this cycle
read_gray_pointer  input  address_size+1  read-domain Gray pointer (asynchronous to write_clk)
overflow_clear  input  1  synchronous clear of write_overflow
write_address  output  address_size  RAM write address = low bits of binary write pointer
write_gray_pointer  output  address_size+1  registered Gray write pointer
write_ram_enable  output  1  combinational: write_inc & ~write_full
write_full  output  1  registered full flag
write_almost_full  output  1  registered almost-full flag
write_level  output  address_size+1  registered occupancy as seen from the write domain (0..depth)
write_overflow  output  1  sticky flag: a write was attempted while full

Behaviour:
- Reset (write_reset=0, asynchronous): the binary pointer, write_gray_pointer, sync flops rq1/rq2, write_full, write_almost_full, write_level and write_overflow all clear to 0. Outputs are valid from the first write_clk edge after release.
- Synchronizer: rq1 <= read_gray_pointer; rq2 <= rq1. Only rq2 is used downstream. No other logic touches read_gray_pointer.
- Pointer update:
  - wbin_next = wbin + (write_inc & ~write_full), modulo 2**(address_size+1).
  - wgray_next = (wbin_next>>1) ^ wbin_next.
  - Both pointers register on each write_clk rising edge.
  - write_address = wbin[address_size-1:0].
- Full:
  - write_full <= (wgray_next == {~rq2[MSB:MSB-1], rq2[MSB-2:0]}).
  - This is evaluated on the post-increment pointer, so full asserts on the same edge that accepts the depth-th write.
- Level:
  - rbin_sync = Gray-to-binary(rq2), using an XOR prefix from the MSB.
  - write_level <= wbin_next - rbin_sync, modulo 2**(address_size+1).
  - write_level == depth exactly when write_full == 1.
- Almost full: write_almost_full <= (wbin_next - rbin_sync) >= depth - almost_full_margin.
- Overflow:
  - On an edge where write_inc=1 and write_full=1, write_overflow <= 1 and the pointer holds.
  - overflow_clear=1 clears it.
  - If set and clear occur on the same edge, set wins.
- Pessimism: flags are conservative.
  - A read-pointer advance deasserts full/almost-full on the 3rd write_clk edge after read_gray_pointer changes (rq1, rq2, flag).
  - Writes can never clear full early.
- Wrap-around: the pointer wraps from 2*depth-1 to 0. Gray continuity holds: exactly one bit of write_gray_pointer changes per accepted write.
- Reset mid-operation: reset takes effect immediately and asynchronously. Any pending write in that cycle is discarded.

Test Plan:
- Reset: assert write_reset=0 mid-stream -> all outputs 0 immediately; after release, write_address=0, write_gray_pointer=5'b00000.
- Fill (address_size=4, read_gray_pointer=0): 16 consecutive write_inc.
  - write_full=1 on the 16th edge, with write_gray_pointer=5'b11000 and write_level=16.
  - write_almost_full=1 from the 14th edge.
  - write_ram_enable=0 afterwards.
- Overflow: from full, write_inc=1 for 1 cycle -> pointer stays 5'b11000 and write_overflow=1. Pulse overflow_clear -> 0; clear plus a new overflowing write on the same edge -> stays 1.
- Drain visibility: while full, set read_gray_pointer=5'b00001 -> write_full=0 and write_level=15 on the 3rd write_clk edge, not earlier.
- Wrap: 40 writes with read_gray_pointer tracking the write pointer from 2 cycles earlier.
  - Binary pointer wraps 31->0.
  - Checker confirms exactly one Gray bit changes per accepted write.
  - write_full is never asserted.
- Simultaneous: at level 15, write_inc=1 while read_gray_pointer advances by one -> full asserts on this edge. It deasserts on the 3rd edge after the read change, with level returning to 15.
